mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl_if.sv | 24 ++
 rtl/mult_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle between a client and the bit-serial multiplier sequencer.
// The client is the master: it offers operands, consumes results and may cancel.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] neuron;
    logic [WIDTH-1:0] weight;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             out_ready;
    logic             abort;

    modport master (
        output in_valid, neuron, weight, out_ready, abort,
        input  in_ready, result, out_valid
    );

    modport slave (
        input  in_valid, neuron, weight, out_ready, abort,
        output in_ready, result, out_valid
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a bit-serial multiplier: latches an operand pair, clears the multiplier,
// streams the weight LSB first, waits for the datapath to settle and captures the product.
//
// state  | meaning
// IDLE   | ready for a new operand pair
// CLEAR  | one-cycle multiplier clear pulse
// SHIFT  | WIDTH cycles of enabled multiply steps, one weight bit each
// DRAIN  | DRAIN_CYCLES idle cycles before sampling mult_out
// DONE   | product presented until the consumer accepts it
module mult_seq_ctrl #(
    parameter int WIDTH        = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    mult_seq_ctrl_if.slave   bus,
    output logic [WIDTH-1:0] mult_input_neuron,
    output logic             mult_weight_bit,
    output logic             mult_enable,
    output logic             mult_reset_n,
    input  logic [WIDTH-1:0] mult_out
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       drain_cnt;
    logic [WIDTH-1:0] weight_sr;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             busy;

    assign busy          = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_DRAIN);
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            bit_cnt           <= '0;
            drain_cnt         <= '0;
            weight_sr         <= '0;
            in_ready_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            result_q          <= '0;
            mult_input_neuron <= '0;
            mult_weight_bit   <= 1'b0;
            mult_enable       <= 1'b0;
            mult_reset_n      <= 1'b0;
        end else if (busy && bus.abort) begin
            // Cancel drops straight back to IDLE; the partial product is never captured.
            state           <= S_IDLE;
            bit_cnt         <= '0;
            in_ready_q      <= 1'b1;
            mult_enable     <= 1'b0;
            mult_weight_bit <= 1'b0;
            mult_reset_n    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready_q   <= 1'b1;
                    mult_reset_n <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        mult_input_neuron <= bus.neuron;
                        weight_sr         <= bus.weight;
                        in_ready_q        <= 1'b0;
                        mult_reset_n      <= 1'b0;
                        state             <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mult_reset_n    <= 1'b1;
                    mult_enable     <= 1'b1;
                    mult_weight_bit <= weight_sr[0];
                    weight_sr       <= weight_sr >> 1;
                    bit_cnt         <= '0;
                    state           <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        mult_enable     <= 1'b0;
                        mult_weight_bit <= 1'b0;
                        drain_cnt       <= DRAIN_LOAD;
                        state           <= S_DRAIN;
                    end else begin
                        bit_cnt         <= bit_cnt + 1'b1;
                        mult_weight_bit <= weight_sr[0];
                        weight_sr       <= weight_sr >> 1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        result_q    <= mult_out;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    mult_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a shift-add multiplier model on the datapath side.
module tb_mult_seq_ctrl;
    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  mult_input_neuron;
    logic              mult_weight_bit;
    logic              mult_enable;
    logic              mult_reset_n;
    logic [WIDTH-1:0]  mult_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .DRAIN_CYCLES(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus.slave),
        .mult_input_neuron (mult_input_neuron),
        .mult_weight_bit   (mult_weight_bit),
        .mult_enable       (mult_enable),
        .mult_reset_n      (mult_reset_n),
        .mult_out          (mult_out)
    );

    // Bit-serial shift-add multiplier: one weight bit per enabled edge, LSB first.
    logic [WIDTH-1:0] acc;
    int               k;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            k   <= 0;
        end else if (!mult_reset_n) begin
            acc <= '0;
            k   <= 0;
        end else if (mult_enable) begin
            if (mult_weight_bit) acc <= acc + WIDTH'(mult_input_neuron << k);
            k <= k + 1;
        end
    end
    assign mult_out = acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic run_op(input logic [15:0] n, input logic [15:0] w, input logic [15:0] p,
                          input int hold, input bit noisy, input bit abort_acc);
        logic [15:0] seq;
        int en_n, rdy_hi, rst_lo, val_hi, stab;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.neuron   = n;
        bus.weight   = w;
        bus.abort    = abort_acc;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        check_val("clear_rst_n", mult_reset_n, 0);
        check_val("clear_en", mult_enable, 0);
        check_val("clear_rdy", bus.in_ready, 0);
        check_val("neuron_latch", mult_input_neuron, n);
        seq = '0; en_n = 0; rdy_hi = 0; rst_lo = 0; val_hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (noisy) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.neuron   = 16'($urandom);
                bus.weight   = 16'($urandom);
            end
            @(negedge clk);
            seq[i] = mult_weight_bit;
            en_n   += int'(mult_enable);
            rdy_hi += int'(bus.in_ready);
            rst_lo += int'(!mult_reset_n);
            val_hi += int'(bus.out_valid);
        end
        bus.in_valid = 1'b0;
        check_val("bit_seq", seq, w);
        check_val("shift_en_cycles", en_n, 16);
        check_val("shift_rdy_high", rdy_hi, 0);
        check_val("shift_rst_low", rst_lo, 0);
        check_val("shift_valid_high", val_hi, 0);
        check_val("neuron_kept", mult_input_neuron, n);
        @(negedge clk);
        check_val("drain_en", mult_enable, 0);
        check_val("drain_bit", mult_weight_bit, 0);
        check_val("drain_valid", bus.out_valid, 0);
        @(negedge clk);
        check_val("valid_at_18", bus.out_valid, 1);
        check_val("result", bus.result, p);
        stab = 0;
        for (int i = 0; i < hold; i++) begin
            bus.abort = 1'b1;
            @(negedge clk);
            if (bus.out_valid && bus.result == p && !bus.in_ready) stab++;
        end
        if (hold > 0) check_val("hold_stable", stab, hold);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        check_val("ack_valid", bus.out_valid, 0);
        check_val("ack_rdy", bus.in_ready, 1);
        check_val("ack_result_held", bus.result, p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.neuron    = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        #12;
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_mult_rst_n", mult_reset_n, 0);
        check_val("rst_valid", bus.out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_rdy", bus.in_ready, 1);
        check_val("post_rst_mult_rst_n", mult_reset_n, 1);

        run_op(16'h6160, 16'h1111, 16'hD760, 0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        run_op(16'h1234, 16'hFFFF, 16'hEDCC, 0, 1'b0, 1'b0);
        run_op(16'h0003, 16'h0005, 16'h000F, 10, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h8001, 16'h80FF, 0, 1'b1, 1'b0);
        run_op(16'h0010, 16'h0010, 16'h0100, 0, 1'b0, 1'b1);

        // Abort while bit 5 is on the serial line.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.neuron   = 16'hAAAA;
        bus.weight   = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_en", mult_enable, 0);
        check_val("abort_rdy", bus.in_ready, 1);
        check_val("abort_valid", bus.out_valid, 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            cnt += int'(bus.out_valid);
        end
        check_val("abort_no_valid", cnt, 0);
        run_op(16'h0102, 16'h0304, 16'h0A08, 0, 1'b0, 1'b0);

        // Reset in the middle of SHIFT.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.neuron   = 16'h5555;
        bus.weight   = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("arst_rdy", bus.in_ready, 0);
        check_val("arst_mult_rst_n", mult_reset_n, 0);
        check_val("arst_en", mult_enable, 0);
        check_val("arst_bit", mult_weight_bit, 0);
        check_val("arst_neuron", mult_input_neuron, 0);
        check_val("arst_result", bus.result, 0);
        check_val("arst_valid", bus.out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("arst_release_rdy", bus.in_ready, 1);
        run_op(16'h7FFF, 16'h0002, 16'hFFFE, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
